// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequences immediate sign-extension, branch-target computation and
// condition resolution for control-flow instructions, then issues a PC redirect with a
// one-cycle flush to fetch. One instruction in flight at a time.
module pc_redirect_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [5:0]  opcode,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  input  logic [31:0] pc_in,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] redirect_cnt
);

  localparam logic [5:0] OP_BRA  = 6'b010110;
  localparam logic [5:0] OP_JUMP = 6'b010101;

  typedef enum logic [1:0] {StIdle, StExt, StCalc, StResp} state_e;

  state_e      state_q;
  logic [5:0]  opcode_q;
  logic [15:0] imm16_q;
  logic [25:0] imm26_q;
  logic [31:0] rs_q;
  logic [31:0] pc_q;
  logic [31:0] offset_q;
  logic        first_q;

  logic        is_jump;
  logic        taken;
  logic [31:0] target;

  // Branch condition and word-aligned target, evaluated from captured operands
  always_comb begin
    is_jump = (opcode_q == OP_JUMP);
    taken   = is_jump || (rs_q != 32'd0);
    // Offset bits shifted past bit 31 are intentionally dropped (modulo 2^32)
    target  = pc_q + 32'd4 + (offset_q << 2);
  end

  // Handshake/flush outputs decoded from registered state and first-cycle flag
  always_comb begin
    instr_ready    = (state_q == StIdle);
    redirect_valid = (state_q == StResp);
    flush          = (state_q == StResp) && first_q;
  end

  // Controller FSM with registered datapath and redirect outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      opcode_q     <= 6'd0;
      imm16_q      <= 16'd0;
      imm26_q      <= 26'd0;
      rs_q         <= 32'd0;
      pc_q         <= 32'd0;
      offset_q     <= 32'd0;
      first_q      <= 1'b0;
      redirect_pc  <= 32'd0;
      redirect_cnt <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            opcode_q <= opcode;
            imm16_q  <= imm16;
            imm26_q  <= imm26;
            rs_q     <= rs_data;
            pc_q     <= pc_in;
            // Non-control opcodes are consumed here without any further action
            if (opcode == OP_BRA || opcode == OP_JUMP) begin
              state_q <= StExt;
            end
          end
        end
        StExt: begin
          offset_q <= is_jump ? {{6{imm26_q[25]}}, imm26_q} : {{16{imm16_q[15]}}, imm16_q};
          state_q  <= StCalc;
        end
        StCalc: begin
          if (taken) begin
            redirect_pc <= target;
            first_q     <= 1'b1;
            state_q     <= StResp;
          end else begin
            state_q <= StIdle;
          end
        end
        StResp: begin
          first_q <= 1'b0;
          if (redirect_ready) begin
            redirect_cnt <= redirect_cnt + 16'd1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: table-driven transactions plus directed
// sequences for backpressure, non-control streams and reset during operation.
module tb_pc_redirect_ctrl;

  localparam logic [5:0] BRA  = 6'b010110;
  localparam logic [5:0] JUMP = 6'b010101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  opcode;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic [31:0] pc_in;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] redirect_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_pc = 32'd0;
  logic [15:0] exp_cnt = 16'd0;

  pc_redirect_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .imm16         (imm16),
    .imm26         (imm26),
    .rs_data       (rs_data),
    .pc_in         (pc_in),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .redirect_cnt  (redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle (cycle T), then follow it through T+4
  task automatic run_instr(input logic [5:0] op, input logic [15:0] i16, input logic [25:0] i26,
                           input logic [31:0] rs, input logic [31:0] pc, input logic tk,
                           input logic [31:0] epc);
    check("ready_before_accept", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    opcode = op; imm16 = i16; imm26 = i26; rs_data = rs; pc_in = pc;
    step();  // T+1: EXT
    instr_valid = 1'b0;
    opcode = 6'd0; imm16 = 16'hdead; imm26 = 26'h1234567; rs_data = 32'd0; pc_in = 32'hffff0000;
    check("ext_ready", {31'd0, instr_ready}, 32'd0);
    check("ext_valid", {31'd0, redirect_valid}, 32'd0);
    step();  // T+2: CALC
    check("calc_valid", {31'd0, redirect_valid}, 32'd0);
    check("calc_flush", {31'd0, flush}, 32'd0);
    step();  // T+3
    if (tk) begin
      last_pc = epc;
      check("resp_valid", {31'd0, redirect_valid}, 32'd1);
      check("resp_flush", {31'd0, flush}, 32'd1);
      check("resp_pc", redirect_pc, epc);
      check("resp_ready", {31'd0, instr_ready}, 32'd0);
      if (redirect_ready) begin
        exp_cnt = exp_cnt + 16'd1;
        step();  // T+4: IDLE
        check("post_valid", {31'd0, redirect_valid}, 32'd0);
        check("post_flush", {31'd0, flush}, 32'd0);
        check("post_cnt", {16'd0, redirect_cnt}, {16'd0, exp_cnt});
        check("post_ready", {31'd0, instr_ready}, 32'd1);
      end
    end else begin
      check("nt_ready", {31'd0, instr_ready}, 32'd1);
      check("nt_valid", {31'd0, redirect_valid}, 32'd0);
      check("nt_flush", {31'd0, flush}, 32'd0);
      check("nt_pc_held", redirect_pc, last_pc);
      check("nt_cnt", {16'd0, redirect_cnt}, {16'd0, exp_cnt});
    end
  endtask

  initial begin
    vecs[0] = '{BRA,  16'h0010, 26'h0000000, 32'd5,         32'h00001000, 1'b1, 32'h00001044};
    vecs[1] = '{BRA,  16'h0010, 26'h0000000, 32'd0,         32'h00001000, 1'b0, 32'h0};
    vecs[2] = '{JUMP, 16'h0000, 26'h3FFFFFF, 32'd0,         32'h00000100, 1'b1, 32'h00000100};
    vecs[3] = '{JUMP, 16'h0000, 26'h0000001, 32'd0,         32'hFFFFFFFC, 1'b1, 32'h00000004};
    vecs[4] = '{BRA,  16'h8000, 26'h0000000, 32'd1,         32'h00000000, 1'b1, 32'hFFFE0004};
    vecs[5] = '{JUMP, 16'h0000, 26'h0000100, 32'd0,         32'h00002000, 1'b1, 32'h00002404};
    vecs[6] = '{BRA,  16'hFFFF, 26'h0000000, 32'h80000000,  32'h00003000, 1'b1, 32'h00003000};

    rst_n = 1'b0; instr_valid = 1'b0; redirect_ready = 1'b1;
    opcode = 6'd0; imm16 = 16'd0; imm26 = 26'd0; rs_data = 32'd0; pc_in = 32'd0;
    step(); step();
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Table-driven transactions
    for (int i = 0; i < 7; i++) begin
      run_instr(vecs[i].op, vecs[i].i16, vecs[i].i26, vecs[i].rs, vecs[i].pc,
                vecs[i].taken, vecs[i].exp_pc);
    end

    // Backpressure: redirect_ready low for 5 RESP cycles
    redirect_ready = 1'b0;
    run_instr(JUMP, 16'h0, 26'h0000002, 32'd0, 32'h00000040, 1'b1, 32'h0000004C);
    for (int i = 1; i < 6; i++) begin
      step();
      if (i == 5) redirect_ready = 1'b1;
      check("bp_valid", {31'd0, redirect_valid}, 32'd1);
      check("bp_flush", {31'd0, flush}, 32'd0);
      check("bp_pc", redirect_pc, 32'h0000004C);
      check("bp_cnt", {16'd0, redirect_cnt}, {16'd0, exp_cnt});
    end
    exp_cnt = exp_cnt + 16'd1;
    step();
    check("bp_done_valid", {31'd0, redirect_valid}, 32'd0);
    check("bp_done_cnt", {16'd0, redirect_cnt}, {16'd0, exp_cnt});

    // Mixed stream: back-to-back non-control opcodes, then a jump
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1; opcode = 6'b000000; pc_in = 32'h500 + 32'(i * 4);
      step();
      check("mix_ready", {31'd0, instr_ready}, 32'd1);
      check("mix_valid", {31'd0, redirect_valid}, 32'd0);
      check("mix_flush", {31'd0, flush}, 32'd0);
      check("mix_cnt", {16'd0, redirect_cnt}, {16'd0, exp_cnt});
    end
    run_instr(JUMP, 16'h0, 26'h0000010, 32'd0, 32'h00000600, 1'b1, 32'h00000644);

    // Reset during CALC of a taken branch
    instr_valid = 1'b1; opcode = BRA; imm16 = 16'h0004; rs_data = 32'd7; pc_in = 32'h00007000;
    step();  // EXT
    instr_valid = 1'b0;
    step();  // CALC
    rst_n = 1'b0;
    step();
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, redirect_valid}, 32'd0);
    check("mid_rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_rst_no_redirect", {31'd0, redirect_valid}, 32'd0);
      check("mid_rst_no_flush", {31'd0, flush}, 32'd0);
    end
    check("mid_rst_pc", redirect_pc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Multi-cycle controller that sequences the immediate sign-extension and branch-target path for control-flow instructions. It accepts one decoded instruction at a time over a valid/ready handshake and sign-extends the 16-bit branch or 26-bit jump immediate to 32 bits. It then computes the word-aligned target, resolves the branch condition and issues a PC redirect plus a one-cycle pipeline flush to fetch. It sits between decode and the fetch/PC register.

## Interface
- OP_BRA, 6'b010110, opcode of conditional branch (taken when rs_data != 0)
- OP_JUMP, 6'b010101, opcode of unconditional jump
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- instr_valid  input  1  decode presents an instruction
- instr_ready  output  1  controller can accept (high only in IDLE)
- opcode  input  6  instruction opcode
- imm16  input  16  branch offset field (words)
- imm26  input  26  jump offset field (words)
- rs_data  input  32  source register value for branch condition
- pc_in  input  32  PC of the presented instruction
- redirect_valid  output  1  redirect_pc is valid
- redirect_ready  input  1  fetch accepts the redirect
- redirect_pc  output  32  new PC
- flush  output  1  one-cycle pulse: kill younger instructions
- redirect_cnt  output  16  count of completed redirects

## Operation
- Clock and reset: one clock; reset is synchronous and active-low.
- FSM states: IDLE, EXT, CALC, RESP.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready: capture opcode, imm16, imm26, rs_data and pc_in.
  - If opcode is OP_BRA or OP_JUMP, go to EXT. Any other opcode is consumed with no output and the FSM stays in IDLE.
- EXT:
  - Register a 32-bit offset.
  - OP_BRA: {{16{imm16[15]}}, imm16}.
  - OP_JUMP: {{6{imm26[25]}}, imm26}.
  - Go to CALC.
- CALC:
  - target = pc + 32'd4 + (offset << 2), modulo 2^32. Bits shifted out are discarded.
  - taken = 1 for OP_JUMP; taken = (rs_data != 0) for OP_BRA.
  - If taken: register target into redirect_pc and go to RESP. Otherwise go to IDLE; redirect_pc is unchanged.
- RESP:
  - redirect_valid=1, with redirect_pc stable for the whole state.
  - flush=1 only in the first RESP cycle.
  - On redirect_valid & redirect_ready: increment redirect_cnt (wraps 0xFFFF→0x0000) and go to IDLE.
- Only one instruction is in flight. Inputs other than the handshake signals are ignored outside the IDLE accept cycle.

## Timing
- Reset (rst_n low at a rising edge): state=IDLE, redirect_valid=0, flush=0, redirect_pc=0, redirect_cnt=0, internal registers=0. instr_ready=1 from the first cycle after reset.
- Reset mid-operation (EXT/CALC/RESP): the in-flight instruction is dropped, no redirect is issued and redirect_cnt is not incremented.
- Taken path:
  - Accept edge T.
  - EXT during cycle T+1.
  - CALC during cycle T+2.
  - redirect_valid and flush high in cycle T+3.
  - Earliest IDLE at T+4 if redirect_ready is high in T+3.
  - Minimum 4 cycles per taken instruction.
- Not-taken branch: instr_ready high again in cycle T+3, with no redirect_valid or flush.
- Non-control opcode: instr_ready stays high and back-to-back accepts are allowed.
- Backpressure: redirect_valid and redirect_pc are held while redirect_ready=0. flush does not repeat. redirect_ready is ignored outside RESP.
- Outputs are registered (flush and redirect_valid are decoded from registered state and a registered first-cycle flag).

## Test plan
- Reset then BRA: pc_in=0x00001000, imm16=0x0010, rs_data=5 → in cycle T+3, redirect_pc=0x00001044, redirect_valid=1, flush=1 for one cycle; redirect_cnt=1 after handshake.
- BRA not taken: rs_data=0, imm16=0x0010 → no redirect_valid and no flush; instr_ready=1 at T+3; redirect_cnt unchanged.
- Negative JUMP and wrap-around:
  - pc_in=0x00000100, imm26=0x3FFFFFF → redirect_pc=0x00000100.
  - pc_in=0xFFFFFFFC, imm26=0x0000001 → redirect_pc=0x00000004.
  - BRA imm16=0x8000, pc_in=0x00000000 → redirect_pc=0xFFFE0004.
- Backpressure: redirect_ready low for 5 cycles in RESP → redirect_valid and redirect_pc stable for 6 cycles; flush high only in the first; exactly one count increment.
- Mixed stream: non-control opcodes 6'b000000 on consecutive cycles are each accepted in one cycle with no outputs; a following JUMP is accepted normally.
- Reset mid-op: rst_n low during CALC of a taken BRA → next cycle IDLE, redirect_valid=0, redirect_cnt=0, and no redirect ever appears for that instruction.
